// File: rtl/countdown_mmss_if.sv
`default_nettype none
// ============================================================================
// countdown_mmss_if
// Control, preset and count-display bundle for the MM:SS countdown timer.
// Revision: 1.0
// ============================================================================
interface countdown_mmss_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [2:0] p_mt;
    logic [3:0] p_mo;
    logic [2:0] p_st;
    logic [3:0] p_so;
    logic [2:0] q_mt;
    logic [3:0] q_mo;
    logic [2:0] q_st;
    logic [3:0] q_so;
    logic       running;
    logic       zero;
    logic       done;

    modport master (
        output tick, load, start, pause, p_mt, p_mo, p_st, p_so,
        input  q_mt, q_mo, q_st, q_so, running, zero, done
    );

    modport slave (
        input  tick, load, start, pause, p_mt, p_mo, p_st, p_so,
        output q_mt, q_mo, q_st, q_so, running, zero, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown_mmss.sv
`default_nettype none
// ============================================================================
// countdown_mmss
// BCD MM:SS countdown timer with load/start/pause control and expiry pulse.
// Optional macro COUNTDOWN_AUTORELOAD_EN: reload the preset on expiry, keep RUN.
// Revision: 1.0
// ============================================================================
module countdown_mmss #(
    parameter int MIN_TENS_MAX = 5
) (
    input  wire              clk,
    input  wire              clr,
    countdown_mmss_if.slave  bus
);
    localparam logic [2:0] MT_MAX = 3'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] cnt_mt, pre_mt, ld_mt, nx_mt;
    logic [3:0] cnt_mo, pre_mo, ld_mo, nx_mo;
    logic [2:0] cnt_st, pre_st, ld_st, nx_st;
    logic [3:0] cnt_so, pre_so, ld_so, nx_so;
    logic       running_r;
    logic       done_r;
    logic       zero_w;
    logic       last_sec;

    // Out-of-range preset digits saturate to the largest legal digit.
    always_comb begin
        ld_mt = (bus.p_mt > MT_MAX) ? MT_MAX : bus.p_mt;
        ld_mo = (bus.p_mo > 4'd9)   ? 4'd9   : bus.p_mo;
        ld_st = (bus.p_st > 3'd5)   ? 3'd5   : bus.p_st;
        ld_so = (bus.p_so > 4'd9)   ? 4'd9   : bus.p_so;
    end

    always_comb begin
        nx_mt = cnt_mt;
        nx_mo = cnt_mo;
        nx_st = cnt_st;
        nx_so = cnt_so - 4'd1;
        if (cnt_so == 4'd0) begin
            nx_so = 4'd9;
            nx_st = cnt_st - 3'd1;
            if (cnt_st == 3'd0) begin
                nx_st = 3'd5;
                nx_mo = cnt_mo - 4'd1;
                if (cnt_mo == 4'd0) begin
                    nx_mo = 4'd9;
                    nx_mt = cnt_mt - 3'd1;
                end
            end
        end
    end

    assign zero_w   = (cnt_mt == 3'd0) && (cnt_mo == 4'd0) &&
                      (cnt_st == 3'd0) && (cnt_so == 4'd0);
    assign last_sec = (cnt_mt == 3'd0) && (cnt_mo == 4'd0) &&
                      (cnt_st == 3'd0) && (cnt_so == 4'd1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt_mt    <= '0;
            cnt_mo    <= '0;
            cnt_st    <= '0;
            cnt_so    <= '0;
            pre_mt    <= '0;
            pre_mo    <= '0;
            pre_st    <= '0;
            pre_so    <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.load) begin
                cnt_mt    <= ld_mt;
                cnt_mo    <= ld_mo;
                cnt_st    <= ld_st;
                cnt_so    <= ld_so;
                pre_mt    <= ld_mt;
                pre_mo    <= ld_mo;
                pre_st    <= ld_st;
                pre_so    <= ld_so;
                state     <= IDLE;
                running_r <= 1'b0;
            end else if (bus.pause) begin
                if (state == RUN) begin
                    state     <= PAUSE;
                    running_r <= 1'b0;
                end
            end else if (bus.start && (state == IDLE || state == PAUSE)) begin
                if (!zero_w) begin
                    state     <= RUN;
                    running_r <= 1'b1;
                end
            end else if (bus.tick && state == RUN && !zero_w) begin
                if (last_sec) begin
                    done_r <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    cnt_mt <= pre_mt;
                    cnt_mo <= pre_mo;
                    cnt_st <= pre_st;
                    cnt_so <= pre_so;
`else
                    cnt_mt    <= '0;
                    cnt_mo    <= '0;
                    cnt_st    <= '0;
                    cnt_so    <= '0;
                    state     <= DONE;
                    running_r <= 1'b0;
`endif
                end else begin
                    cnt_mt <= nx_mt;
                    cnt_mo <= nx_mo;
                    cnt_st <= nx_st;
                    cnt_so <= nx_so;
                end
            end
        end
    end

`ifndef COUNTDOWN_AUTORELOAD_EN
    // The preset register is only read back by the autoreload path.
    logic unused_pre;
    assign unused_pre = ^{pre_mt, pre_mo, pre_st, pre_so};
`endif

    assign bus.q_mt    = cnt_mt;
    assign bus.q_mo    = cnt_mo;
    assign bus.q_st    = cnt_st;
    assign bus.q_so    = cnt_so;
    assign bus.running = running_r;
    assign bus.zero    = zero_w;
    assign bus.done    = done_r;
endmodule
`default_nettype wire

// File: tb/tb_countdown_mmss.sv
`default_nettype none
// ============================================================================
// tb_countdown_mmss
// Directed scoreboard bench for countdown_mmss (MIN_TENS_MAX = 5).
// Revision: 1.0
// ============================================================================
module tb_countdown_mmss;
    typedef struct {
        string       tag;
        logic [16:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    countdown_mmss_if bus ();

    countdown_mmss #(.MIN_TENS_MAX(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] bcd(input int secs);
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
        mt = 3'(secs / 600);
        mo = 4'((secs / 60) % 10);
        st = 3'((secs % 60) / 10);
        so = 4'(secs % 10);
        return {mt, mo, st, so};
    endfunction

    // Expected observation: {mt, mo, st, so, running, zero, done}.
    task automatic push(input string tag, input int secs, input logic run, input logic d);
        exp_t e;
        e.tag = tag;
        e.vec = {bcd(secs), run, (secs == 0), d};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [16:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed none expected entry");
            return;
        end
        e   = sb.pop_front();
        obs = {bus.q_mt, bus.q_mo, bus.q_st, bus.q_so, bus.running, bus.zero, bus.done};
        assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, obs, e.vec);
        end
    endtask

    // One clock with the given strobes and raw preset digits, then compare.
    task automatic step(input logic t, input logic l, input logic s, input logic p,
                        input logic [13:0] pre, input string tag,
                        input int secs, input logic run, input logic d);
        bus.tick  = t;
        bus.load  = l;
        bus.start = s;
        bus.pause = p;
        {bus.p_mt, bus.p_mo, bus.p_st, bus.p_so} = pre;
        push(tag, secs, run, d);
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        check_out();
    endtask

    initial begin
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        {bus.p_mt, bus.p_mo, bus.p_st, bus.p_so} = '0;

        // Reset state, with strobes active to show they are ignored
        bus.load = 1'b1;
        bus.p_so = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        bus.load = 1'b0;
        push("reset", 0, 1'b0, 1'b0);
        check_out();
        clr = 1'b1;

        // Asynchronous abort mid-count, then start on zero count is ignored
        step(0, 1, 0, 0, bcd(60), "load_0100", 60, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_run", 60, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "tick_0059", 59, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        push("clr_async", 0, 1'b0, 1'b0);
        check_out();
        @(negedge clk);
        clr = 1'b1;
        step(0, 0, 1, 0, '0, "start_after_clr", 0, 1'b0, 1'b0);
        step(1, 0, 0, 0, '0, "tick_after_clr", 0, 1'b0, 1'b0);

        // Full minute down to expiry
        step(0, 1, 0, 0, bcd(60), "load_0100b", 60, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_0100", 60, 1'b1, 1'b0);
        for (int n = 59; n >= 1; n--)
            step(1, 0, 0, 0, '0, $sformatf("count_%0d", n), n, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "expire", 0, 1'b0, 1'b1);
        step(0, 0, 0, 0, '0, "done_once", 0, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_in_done", 0, 1'b0, 1'b0);

        // Minute-tens borrow
        step(0, 1, 0, 0, bcd(600), "load_1000", 600, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_1000", 600, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "borrow_0959", 599, 1'b1, 1'b0);

        // Preset clamping
        step(0, 1, 0, 0, {3'd7, 4'd12, 3'd6, 4'd15}, "clamp_5959", 3599, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_5959", 3599, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "tick_5958", 3598, 1'b1, 1'b0);

        // Pause beats a same-cycle tick
        step(0, 1, 0, 0, bcd(10), "load_0010", 10, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_0010", 10, 1'b1, 1'b0);
        step(1, 0, 0, 1, '0, "pause_tick", 10, 1'b0, 1'b0);
        step(1, 0, 0, 0, '0, "tick_in_pause", 10, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "resume", 10, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "tick_0009", 9, 1'b1, 1'b0);

        // Zero load, start ignored, load beats tick
        step(0, 1, 0, 0, bcd(0), "load_0000", 0, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_zero", 0, 1'b0, 1'b0);
        step(1, 1, 0, 0, bcd(5), "load_tick", 5, 1'b0, 1'b0);
        step(1, 0, 0, 0, '0, "tick_in_idle", 5, 1'b0, 1'b0);

        // Expiry with or without autoreload
        step(0, 1, 0, 0, bcd(2), "load_0002", 2, 1'b0, 1'b0);
        step(0, 0, 1, 0, '0, "start_0002", 2, 1'b1, 1'b0);
        step(1, 0, 0, 0, '0, "tick_0001", 1, 1'b1, 1'b0);
`ifdef COUNTDOWN_AUTORELOAD_EN
        step(1, 0, 0, 0, '0, "reload", 2, 1'b1, 1'b1);
        step(0, 0, 0, 0, '0, "reload_done_once", 2, 1'b1, 1'b0);
`else
        step(1, 0, 0, 0, '0, "stop", 0, 1'b0, 1'b1);
        step(0, 0, 0, 0, '0, "stop_done_once", 0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
